// File: rtl/bram_sdp_rd_streamer_if.sv
// Bus bundle between the read streamer, the BRAM read port and the stream consumer.
// The streamer is the master: it drives the BRAM read controls and the stream
// valid/data, and receives the BRAM read data and the stream ready.
interface bram_sdp_rd_streamer_if #(
  parameter int RAM_WIDTH = 64,
  parameter int AW        = 9
);
  logic [AW-1:0]        ram_addrb_o;
  logic                 ram_enb_o;
  logic                 ram_regceb_o;
  logic                 ram_rstb_o;
  logic [RAM_WIDTH-1:0] ram_doutb_i;
  logic                 out_valid_o;
  logic [RAM_WIDTH-1:0] out_data_o;
  logic                 out_ready_i;

  modport master (
    output ram_addrb_o, ram_enb_o, ram_regceb_o, ram_rstb_o,
    output out_valid_o, out_data_o,
    input  ram_doutb_i, out_ready_i
  );

  modport slave (
    input  ram_addrb_o, ram_enb_o, ram_regceb_o, ram_rstb_o,
    input  out_valid_o, out_data_o,
    output ram_doutb_i, out_ready_i
  );
endinterface

// File: rtl/bram_sdp_rd_streamer.sv
// Read-side engine for a single-clock simple-dual-port BRAM used as a circular
// buffer. Issues reads while the writer pointer is ahead and buffer credit is
// available, absorbs the fixed BRAM read latency, and presents entries in order
// on a valid/ready stream. The committed read pointer only advances on a pop.
module bram_sdp_rd_streamer #(
  parameter int    RAM_WIDTH       = 64,
  parameter int    RAM_DEPTH       = 512,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(RAM_DEPTH):0]  wr_ptr_i,
  output logic [$clog2(RAM_DEPTH):0]  rd_ptr_o,
  input  logic                        flush_i,
  output logic                        empty_o,
  output logic [$clog2(RAM_DEPTH):0]  count_o,
  bram_sdp_rd_streamer_if.master      bus
);

  localparam int AW        = $clog2(RAM_DEPTH);
  localparam int LAT       = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  // Enough slots to hold every read in flight plus the head and one spare,
  // so back-to-back issue is never throttled while the consumer keeps up.
  localparam int BUF_DEPTH = LAT + 2;
  localparam int BW        = $clog2(BUF_DEPTH + 1);
  localparam int IW        = $clog2(BUF_DEPTH);

  logic [AW:0]          iss_ptr_q, iss_ptr_d;
  logic [AW:0]          rd_ptr_q,  rd_ptr_d;
  logic [LAT:1]         vld_sr_q,  vld_sr_d;
  logic [IW-1:0]        head_q,    head_d;
  logic [IW-1:0]        tail_q,    tail_d;
  logic [BW-1:0]        occ_q,     occ_d;
  logic [RAM_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic [BW-1:0]        inflight;
  logic                 credit_ok;
  logic                 enb;
  logic                 capture;
  logic                 out_valid;
  logic                 pop;

  // Buffer slot index with wrap at BUF_DEPTH (not necessarily a power of two).
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
    return (i == IW'(BUF_DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  // Count reads issued but not yet captured.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= LAT; i++) inflight = inflight + BW'(vld_sr_q[i]);
  end

  // A same-cycle pop is deliberately ignored so occupancy can never exceed the buffer.
  assign credit_ok = ((BW+1)'(inflight) + (BW+1)'(occ_q)) < (BW+1)'(BUF_DEPTH);
  assign enb       = rst_n & ~flush_i & (iss_ptr_q != wr_ptr_i) & credit_ok;
  assign capture   = vld_sr_q[LAT];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & bus.out_ready_i;

  // Next-state: issue pointer, latency tracker, buffer indices, committed pointer.
  always_comb begin
    iss_ptr_d   = iss_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    vld_sr_d[1] = enb;
    for (int i = 2; i <= LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
    if (flush_i) begin
      // Everything unread or in flight is dropped; restart from the writer.
      iss_ptr_d = wr_ptr_i;
      rd_ptr_d  = wr_ptr_i;
      vld_sr_d  = '0;
      head_d    = '0;
      tail_d    = '0;
      occ_d     = '0;
    end else begin
      if (enb)     iss_ptr_d = iss_ptr_q + 1'b1;
      if (capture) tail_d    = idx_inc(tail_q);
      if (pop) begin
        head_d   = idx_inc(head_q);
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({capture, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      vld_sr_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
    end else begin
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vld_sr_q  <= vld_sr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
    end
  end

  // Capture BRAM read data into the tail slot in the cycle it is valid.
  always_ff @(posedge clk) begin
    if (capture) buf_q[tail_q] <= bus.ram_doutb_i;
  end

  assign bus.ram_addrb_o  = iss_ptr_q[AW-1:0];
  assign bus.ram_enb_o    = enb;
  assign bus.ram_regceb_o = 1'b1;
  assign bus.ram_rstb_o   = ~rst_n | flush_i;
  assign bus.out_valid_o  = out_valid;
  // Empty buffer presents zero so stale slot contents never appear on the bus.
  assign bus.out_data_o   = out_valid ? buf_q[head_q] : '0;

  assign rd_ptr_o = rd_ptr_q;
  assign empty_o  = (rd_ptr_q == wr_ptr_i);
  assign count_o  = wr_ptr_i - rd_ptr_q;

endmodule

// File: tb/tb_bram_sdp_rd_streamer.sv
// Directed/randomized bench for bram_sdp_rd_streamer with a 16-deep BRAM model
// (2-cycle read latency) and an in-order queue reference of written entries.
module tb_bram_sdp_rd_streamer;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int BUFD  = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  wr_ptr = '0;
  logic [4:0]  rd_ptr;
  logic        flush = 1'b0;
  logic        empty;
  logic [4:0]  count;

  bram_sdp_rd_streamer_if #(.RAM_WIDTH(64), .AW(4)) bus ();

  bram_sdp_rd_streamer #(
    .RAM_WIDTH(64), .RAM_DEPTH(DEPTH), .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr_i(wr_ptr), .rd_ptr_o(rd_ptr),
    .flush_i(flush), .empty_o(empty), .count_o(count), .bus(bus)
  );

  always #5 clk = ~clk;

  // BRAM model: read latch then output register (2-cycle latency).
  logic [63:0] mem [DEPTH];
  logic [63:0] ram_lat;
  always_ff @(posedge clk) begin
    if (bus.ram_enb_o) ram_lat <= mem[bus.ram_addrb_o];
    if (bus.ram_rstb_o) bus.ram_doutb_i <= '0;
    else if (bus.ram_regceb_o) bus.ram_doutb_i <= ram_lat;
  end

  // Reference: entries written and not yet consumed, in order.
  logic [63:0] exp_q [$];
  logic [4:0]  exp_rd = '0;
  int          n_vec = 0, n_err = 0;
  int          cyc_n = 0, n_enb = 0, n_beats = 0, first_v = -1, last_v = -1;
  logic        smp_enb, smp_vld, prev_hold = 1'b0;
  logic [3:0]  smp_addr;
  logic [63:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, update the model.
  task automatic cyc(input bit wr, input logic [63:0] d, input bit rdy, input bit fl);
    logic [63:0] dat;
    @(negedge clk);
    if (wr) begin
      mem[wr_ptr[3:0]] = d;
      wr_ptr = wr_ptr + 5'd1;
      exp_q.push_back(d);
    end
    bus.out_ready_i = rdy;
    flush = fl;
    #1;
    cyc_n++;
    smp_enb  = bus.ram_enb_o;
    smp_vld  = bus.out_valid_o;
    smp_addr = bus.ram_addrb_o;
    dat      = bus.out_data_o;
    if (smp_enb) n_enb++;
    chk("rd_ptr", 64'(rd_ptr), 64'(exp_rd));
    chk("count", 64'(count), 64'(5'(wr_ptr - exp_rd)));
    chk("empty", 64'(empty), 64'(exp_rd == wr_ptr));
    if (prev_hold) begin
      chk("hold_valid", 64'(smp_vld), 64'd1);
      chk("hold_data", dat, prev_data);
    end
    if (fl) chk("flush_no_enb", 64'(smp_enb), 64'd0);
    if (smp_vld && rdy && !fl) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("data", dat, exp_q.pop_front());
      exp_rd = exp_rd + 5'd1;
      n_beats++;
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
    end
    prev_hold = smp_vld && !rdy && !fl;
    prev_data = dat;
    if (fl) begin
      exp_q.delete();
      exp_rd = wr_ptr;
    end
  endtask

  // One-cycle reset; the writer restarts from pointer 0 with it.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.out_ready_i = 1'b0;
    flush = 1'b0;
    wr_ptr = '0;
    #1;
    chk("rst_rstb", 64'(bus.ram_rstb_o), 64'd1);
    chk("rst_enb", 64'(bus.ram_enb_o), 64'd0);
    exp_q.delete();
    exp_rd = '0;
    prev_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_data", bus.out_data_o, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rstb_rel", 64'(bus.ram_rstb_o), 64'd0);
    chk("rst_regceb", 64'(bus.ram_regceb_o), 64'd1);
  endtask

  initial begin
    int b0, nw, tog, start, exp_tog;
    logic msb;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.out_ready_i = 1'b0;
    do_reset();

    // 1: single entry, first-beat latency LAT+1 after the pointer moves
    cyc(1, 64'hA5, 1, 0);
    chk("t1_enb", 64'(smp_enb), 64'd1);
    chk("t1_addr", 64'(smp_addr), 64'd0);
    chk("t1_vld_T0", 64'(smp_vld), 64'd0);
    cyc(0, 0, 1, 0); chk("t1_vld_T1", 64'(smp_vld), 64'd0);
    cyc(0, 0, 1, 0); chk("t1_vld_T2", 64'(smp_vld), 64'd0);
    cyc(0, 0, 1, 0); chk("t1_vld_T3", 64'(smp_vld), 64'd1);
    cyc(0, 0, 1, 0);
    chk("t1_vld_after", 64'(smp_vld), 64'd0);
    chk("t1_rd_ptr", 64'(rd_ptr), 64'd1);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_beats", 64'(n_beats), 64'd1);

    // 2: 8 back-to-back entries stream with no bubbles
    b0 = n_beats; first_v = -1; last_v = -1;
    for (int i = 0; i < 8; i++) cyc(1, {$urandom, $urandom}, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("t2_beats", 64'(n_beats - b0), 64'd8);
    chk("t2_span", 64'(last_v - first_v), 64'd7);

    // 3: backpressure, credit limits issue to the buffer depth
    n_enb = 0;
    for (int i = 0; i < 8; i++) cyc(1, {$urandom, $urandom}, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("t3_enb_count", 64'(n_enb), 64'(BUFD));
    chk("t3_enb_idle", 64'(smp_enb), 64'd0);
    chk("t3_valid_held", 64'(smp_vld), 64'd1);
    b0 = n_beats;
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    chk("t3_beats", 64'(n_beats - b0), 64'd8);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: random traffic across pointer wraps
    b0 = n_beats; nw = 0; tog = 0; msb = rd_ptr[4]; start = int'(rd_ptr);
    for (int c = 0; c < 1000 && (nw < 40 || exp_q.size() != 0); c++) begin
      bit w;
      w = (nw < 40) && ($urandom_range(0, 3) != 0) && (5'(wr_ptr - exp_rd) < 5'(DEPTH));
      cyc(w, {$urandom, $urandom}, $urandom_range(0, 3) != 0, 0);
      if (w) nw++;
      if (rd_ptr[4] != msb) begin tog++; msb = rd_ptr[4]; end
    end
    exp_tog = (start + 40) / DEPTH - start / DEPTH;
    chk("t4_written", 64'(nw), 64'd40);
    chk("t4_beats", 64'(n_beats - b0), 64'd40);
    chk("t4_msb_toggles", 64'(tog), 64'(exp_tog));

    // 5: flush with entries buffered and reads in flight
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, {$urandom, $urandom}, 0, 0);
    chk("t5_pre_valid", 64'(smp_vld), 64'd1);
    b0 = n_beats;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    chk("t5_valid0", 64'(smp_vld), 64'd0);
    chk("t5_rd_eq_wr", 64'(rd_ptr), 64'(wr_ptr));
    chk("t5_count0", 64'(count), 64'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("t5_no_stale", 64'(n_beats - b0), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1, {$urandom, $urandom}, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("t5_resume", 64'(n_beats - b0), 64'd3);

    // 6: reset in the middle of a burst, then resume from pointer 0
    for (int i = 0; i < 4; i++) cyc(1, {$urandom, $urandom}, 1, 0);
    do_reset();
    b0 = n_beats;
    for (int i = 0; i < 4; i++) cyc(1, {$urandom, $urandom}, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
    chk("t6_beats", 64'(n_beats - b0), 64'd4);
    chk("t6_rd_ptr", 64'(rd_ptr), 64'd4);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
